// File: rtl/xdisp_mux.sv
// Signed-decimal seven-segment driver: sequential double-dabble conversion into
// sign-magnitude BCD, shown on a free-running multiplexed common-anode display.
module xdisp_mux #(
  parameter int DATA_W      = 11,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              blank_lz,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int NB = DIGITS - 1;
  localparam int BW = 4 * NB;
  localparam int CW = $clog2(DATA_W);
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // conversion work registers
  logic [DATA_W-1:0] r_mag;
  logic              r_neg;
  logic              r_blank;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bcd;
  logic              r_sticky;

  // display registers, only updated in COMMIT
  logic [BW-1:0]     r_dispBcd;
  logic              r_dispNeg;
  logic              r_dispOvf;
  logic              r_dispBlank;

  logic [DW-1:0]     r_div;
  logic [IW-1:0]     r_idx;

  logic [DATA_W-1:0] w_magIn;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_shifted;
  logic              w_carry;
  logic              w_bit;
  logic [NB-1:0]     w_zeroAbove;
  logic              w_run;
  logic [3:0]        w_digit;
  logic              w_lz;

  function automatic logic [7:0] segOf(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sel) w_next = SHIFT;
      SHIFT:   if (r_cnt == '0) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign ovf  = r_dispOvf;

  // the most negative input negates to itself, which is the correct unsigned magnitude
  assign w_magIn = data_in[DATA_W-1] ? ((~data_in) + DATA_W'(1)) : data_in;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NB; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_bit     = r_mag[r_cnt];
  assign w_carry   = w_adj[BW-1];
  assign w_shifted = {w_adj[BW-2:0], w_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag       <= '0;
      r_neg       <= 1'b0;
      r_blank     <= 1'b0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_sticky    <= 1'b0;
      r_dispBcd   <= '0;
      r_dispNeg   <= 1'b0;
      r_dispOvf   <= 1'b0;
      r_dispBlank <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sel) begin
            r_mag    <= w_magIn;
            r_neg    <= data_in[DATA_W-1];
            r_blank  <= blank_lz;
            r_bcd    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= CNT_TOP;
          end
        end
        SHIFT: begin
          r_bcd    <= w_shifted;
          r_sticky <= r_sticky | w_carry;
          r_cnt    <= r_cnt - CW'(1);
        end
        COMMIT: begin
          r_dispBcd   <= r_bcd;
          r_dispNeg   <= r_neg;
          r_dispOvf   <= r_sticky;
          r_dispBlank <= r_blank;
        end
        default: ;
      endcase
    end
  end

  // scan runs independently of conversions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_TOP) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_TOP) ? '0 : r_idx + IW'(1);
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign an = ~(DIGITS'(1) << r_idx);

  // w_zeroAbove[i]: digit i and every numeric digit above it are zero
  always_comb begin
    w_run       = 1'b1;
    w_zeroAbove = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      w_run          = w_run && (r_dispBcd[4*i +: 4] == 4'd0);
      w_zeroAbove[i] = w_run;
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_lz    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = r_dispBcd[4*i +: 4];
        w_lz    = w_zeroAbove[i];
      end
    end
  end

  always_comb begin
    seg = 8'hFF;
    if (r_idx == IDX_TOP)                         seg = r_dispNeg ? 8'hFD : 8'hFF;
    else if (r_dispOvf)                           seg = 8'hFD;
    else if (r_dispBlank && r_idx != '0 && w_lz)  seg = 8'hFF;
    else                                          seg = segOf(w_digit);
  end

endmodule

// File: tb/tb_xdisp_mux.sv
// Directed bench for xdisp_mux: table of loads with expected per-digit segments,
// plus hand-written busy, back-to-back and reset-abort sequences.
module tb_xdisp_mux;
  localparam int DATA_W      = 11;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int CONV_CYC    = DATA_W + 1;
  localparam int SCAN_BOUND  = 4 * REFRESH_DIV * DIGITS;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic [DATA_W-1:0] data_in;
  logic              blank_lz;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] an;
  logic [7:0]        seg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DATA_W-1:0] value;
    logic              blank;
    logic              expOvf;
    logic [3:0][7:0]   expSeg;
  } vec_t;

  vec_t vecs[10];

  xdisp_mux #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .data_in(data_in),
    .blank_lz(blank_lz),
    .busy(busy),
    .ovf(ovf),
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // one-cycle sel pulse; inputs are scrambled afterwards so only the sampled values count
  task automatic applyStimulus(input logic [DATA_W-1:0] value, input logic blank);
    sel      = 1'b1;
    data_in  = value;
    blank_lz = blank;
    @(negedge clk);
    sel      = 1'b0;
    data_in  = ~value;
    blank_lz = ~blank;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic checkDigits(input string name, input logic [3:0][7:0] expSeg);
    logic [DIGITS-1:0] want;
    int n;
    for (int i = 0; i < DIGITS; i++) begin
      want = ~(DIGITS'(1) << i);
      n = 0;
      while (an !== want && n < SCAN_BOUND) begin
        n++;
        @(negedge clk);
      end
      checkOutput($sformatf("%s an%0d", name, i), 32'(an), 32'(want));
      checkOutput($sformatf("%s seg%0d", name, i), 32'(seg), 32'(expSeg[i]));
    end
  endtask

  initial begin
    int cycles;
    int sawBusy;

    // expSeg order: {sign, hundreds, tens, ones}
    vecs[0] = '{11'd987,  1'b0, 1'b0, {8'hFF, 8'h09, 8'h01, 8'h1F}};
    vecs[1] = '{11'h7D3,  1'b1, 1'b0, {8'hFD, 8'hFF, 8'h99, 8'h49}};
    vecs[2] = '{11'd1000, 1'b0, 1'b1, {8'hFF, 8'hFD, 8'hFD, 8'hFD}};
    vecs[3] = '{11'h400,  1'b0, 1'b1, {8'hFD, 8'hFD, 8'hFD, 8'hFD}};
    vecs[4] = '{11'd0,    1'b1, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[5] = '{11'd999,  1'b1, 1'b0, {8'hFF, 8'h09, 8'h09, 8'h09}};
    vecs[6] = '{11'h7FF,  1'b0, 1'b0, {8'hFD, 8'h03, 8'h03, 8'h9F}};
    vecs[7] = '{11'd100,  1'b1, 1'b0, {8'hFF, 8'h9F, 8'h03, 8'h03}};
    vecs[8] = '{11'd10,   1'b1, 1'b0, {8'hFF, 8'hFF, 8'h9F, 8'h03}};
    vecs[9] = '{11'h419,  1'b1, 1'b0, {8'hFD, 8'h09, 8'h09, 8'h09}};

    rst      = 1'b1;
    sel      = 1'b0;
    data_in  = '0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    checkOutput("reset an", 32'(an), 32'h0E);
    checkOutput("reset seg", 32'(seg), 32'h03);
    repeat (4) @(negedge clk);
    checkOutput("scan1 an", 32'(an), 32'h0D);
    checkOutput("scan1 seg", 32'(seg), 32'h03);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].value, vecs[v].blank);
      checkOutput($sformatf("vec%0d busy start", v), 32'(busy), 32'd1);
      waitIdle(cycles);
      checkOutput($sformatf("vec%0d busy cycles", v), 32'(cycles), 32'(CONV_CYC));
      checkOutput($sformatf("vec%0d ovf", v), 32'(ovf), 32'(vecs[v].expOvf));
      checkDigits($sformatf("vec%0d", v), vecs[v].expSeg);
    end

    // sel during busy is dropped without restarting the conversion
    applyStimulus(11'd5, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(11'd7, 1'b1);
    waitIdle(cycles);
    checkOutput("ignore busy cycles", 32'(cycles), 32'(CONV_CYC - 4));
    sawBusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy++;
    end
    checkOutput("ignore no reload", 32'(sawBusy), 32'd0);
    checkDigits("ignore", {8'hFF, 8'h03, 8'h03, 8'h49});

    // earliest reload right after busy drops
    applyStimulus(11'd42, 1'b1);
    waitIdle(cycles);
    checkOutput("b2b first cycles", 32'(cycles), 32'(CONV_CYC));
    applyStimulus(11'd3, 1'b0);
    checkOutput("b2b accepted", 32'(busy), 32'd1);
    waitIdle(cycles);
    checkOutput("b2b second cycles", 32'(cycles), 32'(CONV_CYC));
    checkDigits("b2b", {8'hFF, 8'h03, 8'h03, 8'h0D});

    // reset aborts a conversion and clears the display
    applyStimulus(11'd9, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort ovf", 32'(ovf), 32'd0);
    checkOutput("abort an", 32'(an), 32'h0E);
    checkOutput("abort seg", 32'(seg), 32'h03);
    sawBusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy++;
    end
    checkOutput("abort stays idle", 32'(sawBusy), 32'd0);
    checkDigits("abort", {8'hFF, 8'h03, 8'h03, 8'h03});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xdisp_mux.md
# xdisp_mux

Parametrised signed-decimal seven-segment driver, successor to the fixed 11-bit/4-digit display driver. It converts a signed DATA_W-bit value to sign-magnitude BCD with a sequential double-dabble engine, one input bit per clock. It then time-multiplexes DIGITS-1 decimal digits plus one sign digit onto a common-anode display. Compared with the fixed driver it adds:
- a busy handshake;
- overflow indication;
- optional leading-zero blanking;
- a free-running scan that is never disturbed by new loads.

## Interface
- DATA_W, 11: input width, two's complement, >= 2.
- DIGITS, 4: total display digits; digit DIGITS-1 (leftmost) is the sign digit; DIGITS-1 BCD digits, >= 2.
- REFRESH_DIV, 262144: clk cycles each digit stays enabled, >= 1.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sel  in  1  load strobe; sampled only in IDLE.
- data_in  in  DATA_W  signed value to display.
- blank_lz  in  1  1 = blank leading zeros (ones digit never blanked); sampled with sel.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  displayed value exceeds 10^(DIGITS-1)-1 in magnitude.
- an  out  DIGITS  digit enables, active-low, one-hot-zero; bit 0 = ones digit.
- seg  out  8  segments, active-low; seg[7:1] = a..g, seg[0] = dp (always 1).

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - On sel=1: capture mag = |data_in| as an unsigned DATA_W value. For -2^(DATA_W-1) the magnitude is 2^(DATA_W-1), which fits.
  - Also capture neg = data_in[DATA_W-1] and blank_lz.
  - Clear the BCD work registers and the overflow sticky bit; bit counter = DATA_W-1; go to SHIFT.
- SHIFT, one step per cycle, MSB of mag first:
  - Add 3 to every BCD digit >= 5.
  - Shift the whole BCD chain left by 1, inserting mag[counter] at bit 0.
  - The bit shifted out of the top BCD digit's MSB ORs into the overflow sticky bit.
  - After the counter reaches 0, go to COMMIT.
- COMMIT: copy the BCD work registers, neg, the sticky bit and the blank flag into the display registers atomically; go to IDLE.
- Display registers change only in COMMIT; the shown value never tears mid-conversion.
- sel while busy=1 is ignored, with no queuing.
- Scan:
  - A free-running divider counts REFRESH_DIV cycles, then advances the scan index modulo DIGITS (0,1,..,DIGITS-1,0).
  - an = ~(1 << index).
  - The scan is not reset by sel.
- Digit content:
  - Numeric digit i (i < DIGITS-1) shows its BCD value.
  - If ovf=1, every numeric digit shows '-'.
  - If blank and not ovf, digit i > 0 is blank when it and all numeric digits above it are 0.
  - The sign digit shows '-' if neg, else blank.
- seg encodings (hex): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, '-'=FD, blank=FF. A BCD code above 9 shows FF.
- an and seg are combinational from the scan index and the display registers.

## Timing
- Reset values:
  - State IDLE; busy=0; ovf=0.
  - Display digits all 0, neg=0, blank=0; scan index 0; divider 0.
  - Therefore an = ~1 (all ones except bit 0 low) and seg = 03.
- Load latency:
  - sel sampled at edge 0; busy=1 after edge 0.
  - SHIFT occupies edges 1..DATA_W; COMMIT at edge DATA_W+1.
  - busy=0 and the new display/ovf are visible after edge DATA_W+1.
  - A new sel is accepted at edge DATA_W+2 at the earliest.
- Reset mid-conversion: the conversion is aborted; all registers take their reset values at that edge, and the previous display is not retained.
- Scan switch: the index increments on the edge where the divider equals REFRESH_DIV-1; the divider then wraps to 0. The index wraps from DIGITS-1 to 0.
- Simultaneous sel and scan advance are independent; COMMIT and a scan advance on the same edge are both applied.

## Test plan
(DATA_W=11, DIGITS=4, REFRESH_DIV=4)
- rst for 2 cycles -> busy=0, ovf=0, an=1110, seg=03; after 4 cycles an=1101, seg=03 (blank=0).
- data_in=987, sel 1 cycle, blank_lz=0 -> busy high exactly 12 cycles. Scan then shows:
  - an=1110: 1F
  - an=1101: 01
  - an=1011: 09
  - an=0111: FF
- data_in=-45 (0x7D3), blank_lz=1 -> ovf=0; ones 49, tens 99, hundreds FF, sign FD.
- data_in=1000, then data_in=-1024 (0x400) -> ovf=1 both times; numeric digits FD, sign FF then FD.
- data_in=0, blank_lz=1 -> ones 03, tens/hundreds/sign FF.
- sel with 5, then sel with 7 during busy -> 7 ignored; display 5. rst asserted 3 cycles after sel with 9 -> busy=0, all digits 0, sign blank.
